// File: rtl/code_lock_ctrl.sv
// Sequencing controller for the 4-switch combination lock: input sync, key-press detect, open/alarm/lockout timing.
// Optional code programming while open is enabled by defining CODE_LOCK_PROG_EN.
module code_lock_ctrl #(
  parameter logic [3:0] PASSWORD    = 4'b1111,
  parameter int         OPEN_CYCLES = 50_000_000,
  parameter int         ERR_CYCLES  = 25_000_000,
  parameter int         MAX_FAIL    = 3,
  parameter int         LOCK_CYCLES = 250_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       k,
  input  logic       set,
  output logic       led1,
  output logic       led2,
  output logic [1:0] state,
  output logic [2:0] fail_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPEN    = 2'd1,
    ERR     = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  localparam logic [31:0] OPEN_LOAD = 32'(OPEN_CYCLES - 1);
  localparam logic [31:0] ERR_LOAD  = 32'(ERR_CYCLES - 1);
  localparam logic [31:0] LOCK_LOAD = 32'(LOCK_CYCLES - 1);
  localparam logic [2:0]  FAIL_MAX  = 3'(MAX_FAIL);

  state_t      st;
  logic [31:0] timer;
  logic [3:0]  sw_meta, sw_s;
  logic        k_meta, k_s, k_d;
  logic        press;
  logic [3:0]  code;
  logic [2:0]  fail_next;

  // k idles high, so its synchroniser resets to 1 and reset cannot fake a falling edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta <= 4'b0000;
      sw_s    <= 4'b0000;
      k_meta  <= 1'b1;
      k_s     <= 1'b1;
      k_d     <= 1'b1;
    end else begin
      sw_meta <= sw;
      sw_s    <= sw_meta;
      k_meta  <= k;
      k_s     <= k_meta;
      k_d     <= k_s;
    end
  end

  assign press = k_d & ~k_s;

`ifdef CODE_LOCK_PROG_EN
  logic set_meta, set_s, set_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_meta <= 1'b0;
      set_s    <= 1'b0;
      set_d    <= 1'b0;
      code     <= PASSWORD;
    end else begin
      set_meta <= set;
      set_s    <= set_meta;
      set_d    <= set_s;
      if ((st == OPEN) && set_s && !set_d) begin
        code <= sw_s;
      end else begin
        code <= code;
      end
    end
  end
`else
  logic unused_set;
  assign unused_set = set;
  assign code       = PASSWORD;
`endif

  always_comb begin
    if (fail_cnt < FAIL_MAX) begin
      fail_next = fail_cnt + 3'd1;
    end else begin
      fail_next = FAIL_MAX;
    end
  end

  // LEDs are assigned alongside each state transition so they switch on the same edge as state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      timer    <= 32'd0;
      fail_cnt <= 3'd0;
      led1     <= 1'b1;
      led2     <= 1'b1;
    end else begin
      case (st)
        IDLE: begin
          if (press && (sw_s == code)) begin
            st       <= OPEN;
            timer    <= OPEN_LOAD;
            fail_cnt <= 3'd0;
            led1     <= 1'b0;
            led2     <= 1'b1;
          end else if (press && (fail_next == FAIL_MAX)) begin
            st       <= LOCKOUT;
            timer    <= LOCK_LOAD;
            fail_cnt <= fail_next;
            led1     <= 1'b1;
            led2     <= 1'b0;
          end else if (press) begin
            st       <= ERR;
            timer    <= ERR_LOAD;
            fail_cnt <= fail_next;
            led1     <= 1'b1;
            led2     <= 1'b0;
          end else begin
            st   <= IDLE;
            led1 <= 1'b1;
            led2 <= 1'b1;
          end
        end
        OPEN: begin
          if (timer == 32'd0) begin
            st   <= IDLE;
            led1 <= 1'b1;
            led2 <= 1'b1;
          end else begin
            timer <= timer - 32'd1;
            led1  <= 1'b0;
            led2  <= 1'b1;
          end
        end
        ERR: begin
          if (timer == 32'd0) begin
            st   <= IDLE;
            led1 <= 1'b1;
            led2 <= 1'b1;
          end else begin
            timer <= timer - 32'd1;
            led1  <= 1'b1;
            led2  <= 1'b0;
          end
        end
        LOCKOUT: begin
          if (timer == 32'd0) begin
            st       <= IDLE;
            fail_cnt <= 3'd0;
            led1     <= 1'b1;
            led2     <= 1'b1;
          end else begin
            timer <= timer - 32'd1;
            led1  <= 1'b1;
            led2  <= 1'b0;
          end
        end
        default: begin
          st       <= IDLE;
          timer    <= 32'd0;
          fail_cnt <= 3'd0;
          led1     <= 1'b1;
          led2     <= 1'b1;
        end
      endcase
    end
  end

  assign state = st;

endmodule
